// File: rtl/dx_pkg.sv
// Shared constants and types for the decode/execute boundary buffer.
package dx_pkg;

    // Storage widths of one buffer entry; the ISA field positions below assume 32-bit words.
    localparam int unsigned DX_PC_W   = 32;
    localparam int unsigned DX_DATA_W = 32;

    // Opcodes (insn[31:27]).
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // Instruction field bit positions.
    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 27;
    localparam int unsigned RD_HI    = 26;
    localparam int unsigned RD_LO    = 22;
    localparam int unsigned RS_HI    = 21;
    localparam int unsigned RS_LO    = 17;
    localparam int unsigned RT_HI    = 16;
    localparam int unsigned RT_LO    = 12;
    localparam int unsigned SHAMT_HI = 11;
    localparam int unsigned SHAMT_LO = 7;
    localparam int unsigned ALUOP_HI = 6;
    localparam int unsigned ALUOP_LO = 2;
    localparam int unsigned IMM_HI   = 16;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned TGT_HI   = 26;
    localparam int unsigned TGT_LO   = 0;

    // Architecturally special registers.
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_RA     = 5'd31;

    // One buffered D->X transfer.
    typedef struct packed {
        logic [DX_PC_W-1:0]   pc;
        logic [DX_DATA_W-1:0] insn;
        logic [DX_DATA_W-1:0] r1d;
        logic [DX_DATA_W-1:0] r2d;
    } dx_entry_t;

endpackage

// File: rtl/dx_spec_decode.sv
// Combinational field split and hazard register specifier decode of one instruction.
module dx_spec_decode
    import dx_pkg::*;
(
    input  logic [31:0] insn,
    output logic [4:0]  opcode,
    output logic [4:0]  aluop,
    output logic [4:0]  shamt,
    output logic [16:0] imm,
    output logic [26:0] target,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    logic [4:0] f_rd;
    logic [4:0] f_rs;
    logic [4:0] f_rt;

    // Fixed-position field extraction.
    always_comb begin
        opcode = insn[OPC_HI:OPC_LO];
        aluop  = insn[ALUOP_HI:ALUOP_LO];
        shamt  = insn[SHAMT_HI:SHAMT_LO];
        imm    = insn[IMM_HI:IMM_LO];
        target = insn[TGT_HI:TGT_LO];
        f_rd   = insn[RD_HI:RD_LO];
        f_rs   = insn[RS_HI:RS_LO];
        f_rt   = insn[RT_HI:RT_LO];
    end

    // Registers actually read/written by the instruction, for bypass and stall logic.
    always_comb begin
        rs1 = f_rs;
        rs2 = f_rt;
        rd  = f_rd;

        if (opcode == OP_BEX || opcode == OP_SETX) begin
            rs1 = REG_STATUS;
        end else if (opcode == OP_BNE || opcode == OP_BLT || opcode == OP_JR) begin
            rs1 = f_rd;
        end

        if (opcode == OP_BEX) begin
            rs2 = REG_ZERO;
        end else if (opcode == OP_SW) begin
            rs2 = f_rd;
        end else if (opcode == OP_BNE || opcode == OP_BLT) begin
            rs2 = f_rs;
        end

        if (opcode == OP_JAL) begin
            rd = REG_RA;
        end else if (opcode == OP_SETX) begin
            rd = REG_STATUS;
        end
    end

endmodule

// File: rtl/dx_stage_buf.sv
// Decode/execute boundary: DEPTH-entry elastic buffer with valid/ready, flush and
// occupancy, presenting the decoded head entry to the X stage.
module dx_stage_buf
    import dx_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] insn_in,
    input  logic [DATA_W-1:0] r1d_in,
    input  logic [DATA_W-1:0] r2d_in,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] insn_out,
    output logic [DATA_W-1:0] r1d_out,
    output logic [DATA_W-1:0] r2d_out,
    output logic [4:0]        opcode_out,
    output logic [4:0]        aluop_out,
    output logic [4:0]        shamt_out,
    output logic [16:0]       imm_out,
    output logic [26:0]       target_out,
    output logic [4:0]        rs1_x,
    output logic [4:0]        rs2_x,
    output logic [4:0]        rd_x,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    dx_entry_t        mem_q [DEPTH];
    dx_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic      push;
    logic      pop;
    logic      not_full;
    dx_entry_t head;

    // Handshake flags derive only from registered count, never from out_ready.
    always_comb begin
        not_full  = (count_q != CNT_W'(DEPTH));
        in_ready  = not_full && !reset;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        occupancy = count_q;
    end

    // Next-state for pointers, count and storage; flush overrides push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc:   DX_PC_W'(pc_in),
                                    insn: DX_DATA_W'(insn_in),
                                    r1d:  DX_DATA_W'(r1d_in),
                                    r2d:  DX_DATA_W'(r2d_in)};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; asynchronous reset clears storage as well as control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head is zeroed when empty so the decoder sees insn 0, i.e. a NOP with all specifiers $0.
    always_comb begin
        head     = out_valid ? mem_q[rd_ptr_q] : '0;
        pc_out   = head.pc[PC_W-1:0];
        insn_out = head.insn[DATA_W-1:0];
        r1d_out  = head.r1d[DATA_W-1:0];
        r2d_out  = head.r2d[DATA_W-1:0];
    end

    dx_spec_decode u_spec_decode (
        .insn   (head.insn),
        .opcode (opcode_out),
        .aluop  (aluop_out),
        .shamt  (shamt_out),
        .imm    (imm_out),
        .target (target_out),
        .rs1    (rs1_x),
        .rs2    (rs2_x),
        .rd     (rd_x)
    );

endmodule
